// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the RV32I datapath and its hazard/sequencing controller.
interface pipe_ctrl_if;
  logic        id_valid;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_use_rs1;
  logic        id_use_rs2;
  logic [4:0]  id_rd;
  logic        id_we;
  logic        id_is_load;
  logic        ex_redirect;
  logic        dmem_req;
  logic        dmem_ready;
  logic        pc_en;
  logic        ifid_en;
  logic        idex_en;
  logic        exmem_en;
  logic        memwb_en;
  logic        ifid_flush;
  logic        idex_flush;
  logic [1:0]  fwd_rs1_sel;
  logic [1:0]  fwd_rs2_sel;
  logic [31:0] stall_cycles;

  // Datapath side: reports the ID instruction and memory status, consumes controls.
  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_we, id_is_load,
    output ex_redirect, dmem_req, dmem_ready,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
    input  fwd_rs1_sel, fwd_rs2_sel, stall_cycles
  );

  // Controller side.
  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_we, id_is_load,
    input  ex_redirect, dmem_req, dmem_ready,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
    output fwd_rs1_sel, fwd_rs2_sel, stall_cycles
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Hazard and sequencing controller for the 5-stage RV32I pipeline: scoreboard,
// registered forwarding selects, and combinational stage enables/flushes.
module pipe_ctrl #(
  parameter int unsigned REDIRECT_BUBBLES = 1
) (
  input logic      clk,
  input logic      rst,
  pipe_ctrl_if.slave bus
);

  localparam int unsigned REG_W = 5;
  localparam int unsigned CNT_W = 2;
  localparam int unsigned SEL_W = 2;
  localparam int unsigned STC_W = 32;

  typedef enum logic [1:0] {RUN, MEMWAIT, REDIR} state_e;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             we;
    logic             is_load;
  } slot_t;

  // A slot only produces a hazard if it really writes a non-zero register.
  function automatic logic slot_hit(slot_t s, logic [REG_W-1:0] src);
    return s.valid & s.we & (s.rd != '0) & (s.rd == src);
  endfunction

  // Youngest producer wins; WB at ID time sits in the write-back buffer at EX time.
  function automatic logic [SEL_W-1:0] fwd_sel(logic use_src, logic [REG_W-1:0] src,
                                               slot_t ex, slot_t mem, slot_t wb);
    logic [SEL_W-1:0] sel;
    sel = '0;
    if (use_src && (src != '0)) begin
      if (slot_hit(ex, src))       sel = SEL_W'(1);
      else if (slot_hit(mem, src)) sel = SEL_W'(2);
      else if (slot_hit(wb, src))  sel = SEL_W'(3);
    end
    return sel;
  endfunction

  // The WBBUF position can never match at ID time, so only EX/MEM/WB are stored.
  state_e           state_q, state_d, ret_q, ret_d, eff_state;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  slot_t            ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  logic [SEL_W-1:0] rs1_sel_q, rs1_sel_d, rs2_sel_q, rs2_sel_d;
  logic [STC_W-1:0] stall_q, stall_d;

  logic freeze_c, redirect_c, load_use_c;
  logic pc_en_c, ifid_en_c, idex_en_c, exmem_en_c, memwb_en_c;
  logic ifid_flush_c, idex_flush_c;

  // Event detection from current scoreboard and inputs.
  assign freeze_c   = bus.dmem_req & ~bus.dmem_ready;
  assign redirect_c = bus.ex_redirect & ex_q.valid;
  assign load_use_c = bus.id_valid & ex_q.is_load &
                      ((bus.id_use_rs1 & slot_hit(ex_q, bus.id_rs1)) |
                       (bus.id_use_rs2 & slot_hit(ex_q, bus.id_rs2)));

  // State, scoreboard, select and stall-counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      ret_q     <= RUN;
      cnt_q     <= '0;
      ex_q      <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
      rs1_sel_q <= '0;
      rs2_sel_q <= '0;
      stall_q   <= '0;
    end else begin
      state_q   <= state_d;
      ret_q     <= ret_d;
      cnt_q     <= cnt_d;
      ex_q      <= ex_d;
      mem_q     <= mem_d;
      wb_q      <= wb_d;
      rs1_sel_q <= rs1_sel_d;
      rs2_sel_q <= rs2_sel_d;
      stall_q   <= stall_d;
    end
  end

  // Next-state, pipeline controls and scoreboard advance.
  always_comb begin
    pc_en_c      = 1'b1;
    ifid_en_c    = 1'b1;
    idex_en_c    = 1'b1;
    exmem_en_c   = 1'b1;
    memwb_en_c   = 1'b1;
    ifid_flush_c = 1'b0;
    idex_flush_c = 1'b0;
    state_d      = state_q;
    ret_d        = ret_q;
    cnt_d        = cnt_q;
    ex_d         = ex_q;
    mem_d        = mem_q;
    wb_d         = wb_q;
    rs1_sel_d    = rs1_sel_q;
    rs2_sel_d    = rs2_sel_q;
    stall_d      = stall_q;
    eff_state    = (state_q == MEMWAIT) ? ret_q : state_q;

    if (rst) begin
      pc_en_c      = 1'b0;
      ifid_en_c    = 1'b0;
      idex_en_c    = 1'b0;
      exmem_en_c   = 1'b0;
      memwb_en_c   = 1'b0;
      ifid_flush_c = 1'b1;
      idex_flush_c = 1'b1;
    end else if (freeze_c) begin
      pc_en_c    = 1'b0;
      ifid_en_c  = 1'b0;
      idex_en_c  = 1'b0;
      exmem_en_c = 1'b0;
      memwb_en_c = 1'b0;
      state_d    = MEMWAIT;
      ret_d      = eff_state;
    end else begin
      state_d = eff_state;
      if (redirect_c) begin
        ifid_flush_c = 1'b1;
        idex_flush_c = 1'b1;
        if (REDIRECT_BUBBLES > 1) begin
          state_d = REDIR;
          cnt_d   = CNT_W'(REDIRECT_BUBBLES - 1);
        end
      end else if (eff_state == REDIR) begin
        ifid_flush_c = 1'b1;
        cnt_d        = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) state_d = RUN;
      end else if (load_use_c) begin
        pc_en_c      = 1'b0;
        ifid_en_c    = 1'b0;
        idex_flush_c = 1'b1;
      end

      ex_d.valid   = bus.id_valid & ~idex_flush_c;
      ex_d.rd      = bus.id_rd;
      ex_d.we      = bus.id_we;
      ex_d.is_load = bus.id_is_load;
      mem_d        = ex_q;
      wb_d         = mem_q;
      rs1_sel_d    = ex_d.valid ? fwd_sel(bus.id_use_rs1, bus.id_rs1, ex_q, mem_q, wb_q) : '0;
      rs2_sel_d    = ex_d.valid ? fwd_sel(bus.id_use_rs2, bus.id_rs2, ex_q, mem_q, wb_q) : '0;
    end

    if (!rst && !pc_en_c && (stall_q != '1)) stall_d = stall_q + STC_W'(1);
  end

  assign bus.pc_en        = pc_en_c;
  assign bus.ifid_en      = ifid_en_c;
  assign bus.idex_en      = idex_en_c;
  assign bus.exmem_en     = exmem_en_c;
  assign bus.memwb_en     = memwb_en_c;
  assign bus.ifid_flush   = ifid_flush_c;
  assign bus.idex_flush   = idex_flush_c;
  assign bus.fwd_rs1_sel  = rs1_sel_q;
  assign bus.fwd_rs2_sel  = rs2_sel_q;
  assign bus.stall_cycles = stall_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl (REDIRECT_BUBBLES=3): directed scenarios then random traffic,
// compared against an instruction-level reference model.
module tb_pipe_ctrl;

  localparam int B = 3;

  logic clk;
  logic rst;
  pipe_ctrl_if bus ();

  pipe_ctrl #(.REDIRECT_BUBBLES(B)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    bit       v;
    bit [4:0] rd;
    bit       we;
    bit       ld;
  } mslot_t;

  // Reference: in-flight producers, youngest first (EX, MEM, WB).
  mslot_t    pipe [3];
  int        redir_left;
  int        n_redir;
  bit [31:0] stall_m;
  bit [1:0]  sel1_m, sel2_m;
  bit        e_pc, e_ifen, e_idex, e_exmem, e_memwb, e_iff, e_idf;

  int n_chk;
  int n_fail;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit hit(mslot_t s, bit [4:0] src);
    return s.v && s.we && (s.rd != 0) && (s.rd == src);
  endfunction

  function automatic bit [1:0] fsel(bit u, bit [4:0] src);
    if (!u || src == 0) return 2'd0;
    for (int k = 0; k < 3; k++)
      if (hit(pipe[k], src)) return 2'(k + 1);
    return 2'd0;
  endfunction

  function automatic bit load_use();
    return bus.id_valid && pipe[0].ld &&
           ((bus.id_use_rs1 && hit(pipe[0], bus.id_rs1)) ||
            (bus.id_use_rs2 && hit(pipe[0], bus.id_rs2)));
  endfunction

  task automatic model_comb();
    bit frz;
    frz = bus.dmem_req && !bus.dmem_ready;
    {e_pc, e_ifen, e_idex, e_exmem, e_memwb} = 5'b11111;
    {e_iff, e_idf} = 2'b00;
    n_redir = redir_left;
    if (rst) begin
      {e_pc, e_ifen, e_idex, e_exmem, e_memwb} = 5'b00000;
      {e_iff, e_idf} = 2'b11;
    end else if (frz) begin
      {e_pc, e_ifen, e_idex, e_exmem, e_memwb} = 5'b00000;
    end else if (bus.ex_redirect && pipe[0].v) begin
      {e_iff, e_idf} = 2'b11;
      n_redir = B - 1;
    end else if (redir_left > 0) begin
      e_iff = 1'b1;
      n_redir = redir_left - 1;
    end else if (load_use()) begin
      e_pc = 1'b0;
      e_ifen = 1'b0;
      e_idf = 1'b1;
    end
  endtask

  task automatic model_edge();
    bit frz;
    bit nv;
    frz = bus.dmem_req && !bus.dmem_ready;
    if (rst) begin
      for (int k = 0; k < 3; k++) pipe[k] = '0;
      redir_left = 0;
      sel1_m = 0;
      sel2_m = 0;
      stall_m = 0;
    end else begin
      if (!e_pc && stall_m != 32'hFFFF_FFFF) stall_m = stall_m + 1;
      if (!frz) begin
        nv = bus.id_valid && !e_idf;
        sel1_m = nv ? fsel(bus.id_use_rs1, bus.id_rs1) : 2'd0;
        sel2_m = nv ? fsel(bus.id_use_rs2, bus.id_rs2) : 2'd0;
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = {nv, bus.id_rd, bus.id_we, bus.id_is_load};
        redir_left = n_redir;
      end
    end
  endtask

  task automatic check_all();
    chk1("pc_en", bus.pc_en, e_pc);
    chk1("ifid_en", bus.ifid_en, e_ifen);
    chk1("idex_en", bus.idex_en, e_idex);
    chk1("exmem_en", bus.exmem_en, e_exmem);
    chk1("memwb_en", bus.memwb_en, e_memwb);
    chk1("ifid_flush", bus.ifid_flush, e_iff);
    chk1("idex_flush", bus.idex_flush, e_idf);
    chk32("fwd_rs1_sel", 32'(bus.fwd_rs1_sel), 32'(sel1_m));
    chk32("fwd_rs2_sel", 32'(bus.fwd_rs2_sel), 32'(sel2_m));
    chk32("stall_cycles", bus.stall_cycles, stall_m);
  endtask

  // One clock: check against the model mid-cycle, then advance both.
  task automatic tick();
    #1;
    model_comb();
    check_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.id_valid = 0; bus.id_rs1 = 0; bus.id_rs2 = 0;
    bus.id_use_rs1 = 0; bus.id_use_rs2 = 0;
    bus.id_rd = 0; bus.id_we = 0; bus.id_is_load = 0;
    bus.ex_redirect = 0; bus.dmem_req = 0; bus.dmem_ready = 0;
  endtask

  task automatic instr(input bit [4:0] rd, input bit we, input bit ld,
                       input bit [4:0] rs1, input bit [4:0] rs2, input bit u1, input bit u2);
    bus.id_valid = 1; bus.id_rd = rd; bus.id_we = we; bus.id_is_load = ld;
    bus.id_rs1 = rs1; bus.id_rs2 = rs2; bus.id_use_rs1 = u1; bus.id_use_rs2 = u2;
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    redir_left = 0;
    stall_m = 0;
    sel1_m = 0;
    sel2_m = 0;
    for (int k = 0; k < 3; k++) pipe[k] = '0;

    // Reset
    rst = 1;
    idle();
    @(posedge clk);
    @(negedge clk);
    #1;
    chk1("rst_pc_en", bus.pc_en, 1'b0);
    chk1("rst_ifid_flush", bus.ifid_flush, 1'b1);
    chk1("rst_idex_flush", bus.idex_flush, 1'b1);
    tick();
    rst = 0;
    #1;
    chk1("run_pc_en", bus.pc_en, 1'b1);
    chk32("run_stall", bus.stall_cycles, 32'd0);
    chk32("run_sel1", 32'(bus.fwd_rs1_sel), 32'd0);
    tick();

    // Forwarding at distances 1..4
    for (int d = 1; d <= 4; d++) begin
      instr(5, 1, 0, 0, 0, 0, 0);
      tick();
      for (int j = 1; j < d; j++) begin
        idle();
        tick();
      end
      instr(6, 1, 0, 5, 5, 1, 1);
      tick();
      idle();
      #1;
      chk32($sformatf("fwd_d%0d_rs1", d), 32'(bus.fwd_rs1_sel), (d <= 3) ? 32'(d) : 32'd0);
      chk32($sformatf("fwd_d%0d_rs2", d), 32'(bus.fwd_rs2_sel), (d <= 3) ? 32'(d) : 32'd0);
      repeat (4) tick();
    end

    // x0 destination never forwards
    instr(0, 1, 0, 0, 0, 0, 0);
    tick();
    instr(6, 1, 0, 0, 0, 1, 1);
    tick();
    idle();
    #1;
    chk32("fwd_x0", 32'(bus.fwd_rs1_sel), 32'd0);
    repeat (4) tick();

    // Load-use interlock
    chk32("lu_stall_pre", bus.stall_cycles, 32'd0);
    instr(7, 1, 1, 0, 0, 0, 0);
    tick();
    instr(8, 1, 0, 7, 1, 1, 1);
    #1;
    chk1("lu_pc_en", bus.pc_en, 1'b0);
    chk1("lu_ifid_en", bus.ifid_en, 1'b0);
    chk1("lu_idex_flush", bus.idex_flush, 1'b1);
    tick();
    #1;
    chk1("lu_once", bus.pc_en, 1'b1);
    chk32("lu_stall_post", bus.stall_cycles, 32'd1);
    tick();
    idle();
    #1;
    chk32("lu_sel1", 32'(bus.fwd_rs1_sel), 32'd2);
    chk32("lu_sel2", 32'(bus.fwd_rs2_sel), 32'd0);
    repeat (4) tick();

    // Redirect with three bubbles
    instr(9, 1, 0, 0, 0, 0, 0);
    tick();
    idle();
    bus.ex_redirect = 1;
    #1;
    chk1("rd0_pc_en", bus.pc_en, 1'b1);
    chk1("rd0_ifid_flush", bus.ifid_flush, 1'b1);
    chk1("rd0_idex_flush", bus.idex_flush, 1'b1);
    tick();
    bus.ex_redirect = 0;
    for (int j = 1; j <= 2; j++) begin
      #1;
      chk1($sformatf("rd%0d_ifid_flush", j), bus.ifid_flush, 1'b1);
      chk1($sformatf("rd%0d_idex_flush", j), bus.idex_flush, 1'b0);
      chk1($sformatf("rd%0d_pc_en", j), bus.pc_en, 1'b1);
      tick();
    end
    #1;
    chk1("rd_done", bus.ifid_flush, 1'b0);
    bus.ex_redirect = 1;
    #1;
    chk1("rd_unqual", bus.ifid_flush, 1'b0);
    tick();
    idle();

    // Memory wait of four cycles with a live forwarding select
    instr(10, 1, 0, 0, 0, 0, 0);
    tick();
    instr(11, 1, 0, 10, 10, 1, 1);
    tick();
    idle();
    bus.dmem_req = 1;
    for (int j = 0; j < 4; j++) begin
      #1;
      chk1("mw_pc_en", bus.pc_en, 1'b0);
      chk1("mw_memwb_en", bus.memwb_en, 1'b0);
      chk32("mw_sel1", 32'(bus.fwd_rs1_sel), 32'd1);
      tick();
    end
    bus.dmem_ready = 1;
    #1;
    chk1("mw_release", bus.exmem_en, 1'b1);
    chk32("mw_stall", bus.stall_cycles, 32'd5);
    tick();
    #1;
    chk1("mw_zero_cost", bus.pc_en, 1'b1);
    tick();
    idle();

    // Redirect collides with load-use
    instr(12, 1, 1, 0, 0, 0, 0);
    tick();
    instr(13, 1, 0, 12, 0, 1, 0);
    bus.ex_redirect = 1;
    #1;
    chk1("col_pc_en", bus.pc_en, 1'b1);
    chk1("col_ifid_flush", bus.ifid_flush, 1'b1);
    chk1("col_idex_flush", bus.idex_flush, 1'b1);
    tick();
    idle();
    #1;
    chk32("col_stall", bus.stall_cycles, 32'd5);
    repeat (2) tick();

    // Redirect held through a freeze
    instr(14, 1, 0, 0, 0, 0, 0);
    tick();
    idle();
    bus.ex_redirect = 1;
    bus.dmem_req = 1;
    #1;
    chk1("rf_frozen_flush", bus.ifid_flush, 1'b0);
    tick();
    bus.dmem_ready = 1;
    #1;
    chk1("rf_rel_pc_en", bus.pc_en, 1'b1);
    chk1("rf_rel_idex_flush", bus.idex_flush, 1'b1);
    tick();
    idle();
    tick();

    // Reset in the middle of REDIR
    rst = 1;
    #1;
    chk1("rr_ifid_en", bus.ifid_en, 1'b0);
    chk1("rr_idex_flush", bus.idex_flush, 1'b1);
    tick();
    rst = 0;
    #1;
    chk1("rr_pc_en", bus.pc_en, 1'b1);
    chk1("rr_ifid_flush", bus.ifid_flush, 1'b0);
    chk32("rr_stall", bus.stall_cycles, 32'd0);
    chk32("rr_sel1", 32'(bus.fwd_rs1_sel), 32'd0);
    tick();

    // Random traffic with dense register reuse
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(199) == 0);
      bus.id_valid = 1'($urandom_range(3) != 0);
      bus.id_rd = 5'($urandom_range(7));
      bus.id_rs1 = 5'($urandom_range(7));
      bus.id_rs2 = 5'($urandom_range(7));
      bus.id_use_rs1 = 1'($urandom_range(1));
      bus.id_use_rs2 = 1'($urandom_range(1));
      bus.id_we = 1'($urandom_range(3) != 0);
      bus.id_is_load = 1'($urandom_range(2) == 0);
      bus.ex_redirect = ($urandom_range(9) == 0);
      bus.dmem_req = ($urandom_range(4) == 0);
      bus.dmem_ready = 1'($urandom_range(1));
      tick();
    end
    rst = 0;
    idle();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
